// File: rtl/cnt_seq_pkg.sv
// Shared types for the counter command sequencer.
//   op_e    : command opcode carried on cmd_op
//   state_e : sequencer FSM states
//   cmd_t   : one queued command (opcode, load value, run length)
// The field widths of cmd_t fix the default WIDTH / LEN_W of cnt_cmd_seq.
package cnt_seq_pkg;

  localparam int SEQ_WIDTH = 4;
  localparam int SEQ_LEN_W = 8;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'b00,
    OP_RUN_UP   = 2'b01,
    OP_RUN_DOWN = 2'b10,
    OP_NOP      = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,  // any single-cycle command: LOAD or NOP
    RUN  = 2'd2
  } state_e;

  typedef struct packed {
    op_e                  op;
    logic [SEQ_WIDTH-1:0] val;
    logic [SEQ_LEN_W-1:0] len;
  } cmd_t;

  // RUN_UP and RUN_DOWN are the only multi-cycle commands.
  function automatic logic is_run(input op_e op);
    return (op == OP_RUN_UP) || (op == OP_RUN_DOWN);
  endfunction

endpackage

// File: rtl/cnt_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of cmd_t.
//   clk, rstn   : clock, asynchronous active-low reset (clears pointers)
//   push, din   : write request and payload; ignored when full
//   pop, dout   : read request; dout always shows the head entry
//   full, empty : derived from pointer compare
// Pointers carry one extra wrap bit so all DEPTH entries are usable.
module cnt_cmd_fifo
  import cnt_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  cmd_t din,
  input  logic pop,
  output cmd_t dout,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          do_push;
  logic          do_pop;

  // Same index with different wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg[AW-1:0]] <= din;
    end
  end

  // Head is read combinationally so the sequencer can start a command in
  // the same cycle it pops it, which keeps back-to-back commands bubble-free.
  assign dout = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cnt_cmd_seq.sv
// Command sequencer in front of an up/down counter.
//   clk, rstn          : clock, asynchronous active-low reset
//   cmd_valid/ready    : command handshake; cmd_ready = !full
//   cmd_op/val/len     : opcode, LOAD value, RUN length (run = len+1 cycles)
//   load/load_en/down  : registered drive to the counter
//   rollover           : counter at all-ones
//   busy               : a command is executing
//   done               : one-cycle pulse on the last cycle of each command
//   wrap_clr           : synchronous clear of wrap_cnt
//   wrap_cnt           : saturating count of rollover rising edges while busy
module cnt_cmd_seq
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int DEPTH = 4,
  parameter int LEN_W = SEQ_LEN_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] load,
  output logic             load_en,
  output logic             down,
  input  logic             rollover,
  output logic             busy,
  output logic             done,
  input  logic             wrap_clr,
  output logic [CNT_W-1:0] wrap_cnt
);

  cmd_t             push_cmd;
  cmd_t             head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             last;

  state_e           state_reg;
  state_e           state_next;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] len_next;

  logic [WIDTH-1:0] load_next;
  logic             load_en_next;
  logic             down_next;
  logic             busy_next;
  logic             done_next;

  logic             rollover_q;
  logic             wrap_event;

  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign push_cmd  = '{op: op_e'(cmd_op), val: cmd_val, len: cmd_len};

  cnt_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Final cycle of the running command; the next one may start right after.
  assign last = (state_reg == LOAD) || ((state_reg == RUN) && (len_reg == '0));
  assign pop  = !empty && ((state_reg == IDLE) || last);

  // State register, including the registered counter drive.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      load      <= '0;
      load_en   <= 1'b0;
      down      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      load      <= load_next;
      load_en   <= load_en_next;
      down      <= down_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

  // Next state and run-length counter.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    if (pop) begin
      if (is_run(head.op)) begin
        state_next = RUN;
        len_next   = head.len;
      end else begin
        state_next = LOAD;
        len_next   = '0;
      end
    end else if ((state_reg == IDLE) || last) begin
      state_next = IDLE;
      len_next   = '0;
    end else begin
      len_next   = len_reg - LEN_W'(1);
    end
  end

  // Output values for the coming cycle. load and down hold unless a command
  // explicitly sets them, so the counter keeps its last direction when idle.
  always_comb begin
    load_next    = load;
    load_en_next = 1'b0;
    down_next    = down;
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == LOAD) || ((state_next == RUN) && (len_next == '0));
    if (pop) begin
      case (head.op)
        OP_LOAD: begin
          load_en_next = 1'b1;
          load_next    = head.val;
        end
        OP_RUN_UP:   down_next = 1'b0;
        OP_RUN_DOWN: down_next = 1'b1;
        default:     ;  // NOP changes nothing but occupies one busy cycle
      endcase
    end
  end

  // Wrap events: rising edge of rollover while a command is executing.
  assign wrap_event = rollover && !rollover_q && busy;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rollover_q <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      rollover_q <= rollover;
      if (wrap_clr) begin
        wrap_cnt <= '0;
      end else if (wrap_event && !(&wrap_cnt)) begin
        wrap_cnt <= wrap_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cnt_cmd_seq.sv
`timescale 1ns/1ps
module tb_cnt_cmd_seq;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int LW = 8;
  localparam int CW = 8;

  localparam logic [1:0] LD = 2'b00;
  localparam logic [1:0] UP = 2'b01;
  localparam logic [1:0] DN = 2'b10;
  localparam logic [1:0] NP = 2'b11;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [W-1:0]  cmd_val = '0;
  logic [LW-1:0] cmd_len = '0;
  logic [W-1:0]  load;
  logic          load_en;
  logic          down;
  logic          rollover;
  logic          busy;
  logic          done;
  logic          wrap_clr = 1'b0;
  logic [CW-1:0] wrap_cnt;
  logic [W-1:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnt_cmd_seq #(
    .WIDTH (W),
    .DEPTH (D),
    .LEN_W (LW),
    .CNT_W (CW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_val   (cmd_val),
    .cmd_len   (cmd_len),
    .load      (load),
    .load_en   (load_en),
    .down      (down),
    .rollover  (rollover),
    .busy      (busy),
    .done      (done),
    .wrap_clr  (wrap_clr),
    .wrap_cnt  (wrap_cnt)
  );

  // Stand-in for the downstream up/down counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        count <= '0;
    else if (load_en) count <= load;
    else if (down)    count <= count - W'(1);
    else              count <= count + W'(1);
  end
  assign rollover = &count;

  typedef struct {
    logic [1:0]    op;
    logic [W-1:0]  val;
    logic [LW-1:0] len;
  } bcmd_t;

  // Reference model: queued commands, cycles left in the current command,
  // and the outputs the sequencer should present this cycle.
  bcmd_t         mq[$];
  bcmd_t         sb_q[$];
  int            rem;
  int            cyc;
  logic          e_busy, e_load_en, e_down, e_done;
  logic [W-1:0]  e_load;
  logic [W-1:0]  m_count;
  logic          m_roll_q;
  logic [CW-1:0] m_wrap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    sb_q.delete();
    rem = 0; cyc = 0;
    e_busy = 0; e_load_en = 0; e_down = 0; e_done = 0; e_load = '0;
    m_count = '0; m_roll_q = 0; m_wrap = '0;
  endtask

  // Monitor: compares every cycle against the model, and pops the command
  // scoreboard each time the DUT signals done.
  initial begin
    bcmd_t c;
    bcmd_t c_in;
    bit    do_push;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rstn) begin
        model_reset();
      end else begin
        chk("busy",      32'(busy),      32'(e_busy));
        chk("load_en",   32'(load_en),   32'(e_load_en));
        chk("load",      32'(load),      32'(e_load));
        chk("down",      32'(down),      32'(e_down));
        chk("done",      32'(done),      32'(e_done));
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < D));
        chk("count",     32'(count),     32'(m_count));
        chk("wrap_cnt",  32'(wrap_cnt),  32'(m_wrap));

        if (busy) cyc++;
        else      cyc = 0;
        if (done) begin
          if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_pop: done seen with no issued command outstanding (t=%0t)", $time);
          end else begin
            c = sb_q.pop_front();
            chk("sb_cycles", 32'(cyc), 32'(((c.op == UP) || (c.op == DN)) ? int'(c.len) + 1 : 1));
            case (c.op)
              LD: begin
                chk("sb_load_en", 32'(load_en), 32'd1);
                chk("sb_load",    32'(load),    32'(c.val));
              end
              UP: chk("sb_down_up", 32'(down), 32'd0);
              DN: chk("sb_down_dn", 32'(down), 32'd1);
              default: chk("sb_nop_load_en", 32'(load_en), 32'd0);
            endcase
          end
          cyc = 0;
        end

        // Advance the model across the coming clock edge.
        do_push = cmd_valid && (mq.size() < D);
        c_in    = '{cmd_op, cmd_val, cmd_len};
        if (wrap_clr) m_wrap = '0;
        else if ((&m_count) && !m_roll_q && e_busy && (m_wrap != '1)) m_wrap = m_wrap + 1'b1;
        m_roll_q = &m_count;
        m_count  = e_load_en ? e_load : (e_down ? m_count - 1'b1 : m_count + 1'b1);

        e_load_en = 0;
        if ((rem <= 1) && (mq.size() > 0)) begin
          c = mq.pop_front();
          e_busy = 1;
          rem = ((c.op == UP) || (c.op == DN)) ? int'(c.len) + 1 : 1;
          if (c.op == LD) begin
            e_load_en = 1;
            e_load    = c.val;
          end else if (c.op == UP) begin
            e_down = 0;
          end else if (c.op == DN) begin
            e_down = 1;
          end
        end else if (rem <= 1) begin
          rem = 0;
          e_busy = 0;
        end else begin
          rem--;
        end
        e_done = (rem == 1);
        if (do_push) mq.push_back(c_in);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offer one command and hold it until accepted (bounded).
  task automatic send(input logic [1:0] op, input logic [W-1:0] val, input logic [LW-1:0] len);
    bit ok;
    int n;
    cmd_valid = 1; cmd_op = op; cmd_val = val; cmd_len = len;
    ok = 0; n = 0;
    while (!ok && n < 3000) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      n++;
    end
    #1;
    cmd_valid = 0;
    if (ok) begin
      sb_q.push_back('{op, val, len});
      $display("cmd op=%0d val=%0h len=%0d accepted after %0d cycle(s)", op, val, len, n);
    end else begin
      total++; bad++;
      $display("FAIL send_timeout: cmd_ready low for %0d cycles, required acceptance", n);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((e_busy || (mq.size() != 0)) && n < 8000);
    #1;
    if (n >= 8000) begin
      total++; bad++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", n);
    end
  endtask

  initial begin
    #2;
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_load_en",   32'(load_en),   32'd0);
    chk("rst_load",      32'(load),      32'd0);
    chk("rst_down",      32'(down),      32'd0);
    chk("rst_done",      32'(done),      32'd0);
    chk("rst_wrap",      32'(wrap_cnt),  32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    tick(1);

    // Single LOAD.
    send(LD, 4'h9, 8'd0);
    wait_idle();
    tick(2);

    // LOAD then RUN_DOWN back to back (wraps through 0xF).
    send(LD, 4'h0, 8'd0);
    send(DN, 4'h0, 8'd2);
    wait_idle();

    // Fill the FIFO behind a long RUN; the fifth command must wait.
    send(UP, 4'h0, 8'd30);
    send(LD, 4'h3, 8'd0);
    send(DN, 4'h0, 8'd1);
    send(NP, 4'h0, 8'd0);
    send(UP, 4'h0, 8'd2);
    @(negedge clk);
    chk("ready_when_full", 32'(cmd_ready), 32'd0);
    tick(1);
    send(LD, 4'hA, 8'd0);
    wait_idle();

    // Wrap counting and saturation.
    send(LD, 4'hE, 8'd0);
    send(UP, 4'h0, 8'd5);
    for (int i = 0; i < 20; i++) send(UP, 4'h0, 8'd255);
    wait_idle();
    chk("wrap_saturated", 32'(wrap_cnt), 32'hFF);
    wrap_clr = 1;
    tick(1);
    wrap_clr = 0;
    chk("wrap_cleared", 32'(wrap_cnt), 32'd0);

    // Asynchronous reset in the middle of a RUN with commands queued.
    send(UP, 4'h0, 8'd40);
    send(LD, 4'h5, 8'd0);
    send(DN, 4'h0, 8'd3);
    send(NP, 4'h0, 8'd0);
    tick(5);
    #2 rstn = 0;
    #1;
    chk("arst_busy",      32'(busy),      32'd0);
    chk("arst_load_en",   32'(load_en),   32'd0);
    chk("arst_load",      32'(load),      32'd0);
    chk("arst_down",      32'(down),      32'd0);
    chk("arst_done",      32'(done),      32'd0);
    chk("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    tick(2);
    rstn = 1;
    tick(10);
    chk("post_reset_idle", 32'(busy), 32'd0);

    // Single-cycle commands.
    send(NP, 4'h3, 8'd0);
    send(DN, 4'h0, 8'd0);
    send(NP, 4'h0, 8'd0);
    send(UP, 4'h0, 8'd0);
    send(LD, 4'h5, 8'd0);
    wait_idle();

    // Random traffic with random gaps and occasional wrap clears.
    for (int i = 0; i < 150; i++) begin
      wrap_clr = ($urandom_range(0, 15) == 0);
      send(2'($urandom_range(0, 3)), W'($urandom_range(0, 15)), LW'($urandom_range(0, 6)));
      wrap_clr = 0;
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 5));
    end
    wait_idle();
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
